// File: rtl/fma_sched.sv
// rtl/fma_sched.sv - FMA pipe scheduler: adder/writeback-port reservation, wakeup and writeback tags.
// Define FMA_SCHED_FLUSH_EN to build the redirect kill of younger in-flight ops.
module fma_sched #(
  parameter int MUL_LAT    = 3,
  parameter int ADD_LAT    = 2,
  parameter int WAKE_AHEAD = 1,
  parameter int PREG_W     = 7,
  parameter int ROB_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [PREG_W-1:0] in_rd,
  input  logic [ROB_W-1:0]  in_rob,
  output logic              in_ready,
  output logic              mul_start,
  output logic              add_start,
  output logic              add_fma,
  output logic              wakeup_valid,
  output logic [PREG_W-1:0] wakeup_rd,
  output logic              wb_valid,
  output logic [PREG_W-1:0] wb_rd,
  output logic [ROB_W-1:0]  wb_rob,
  output logic              wb_from_mul,
  input  logic              flush_en,
  input  logic [ROB_W-1:0]  flush_rob
);
  localparam int D  = MUL_LAT + ADD_LAT;
  localparam int LW = $clog2(D + 1);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd1;
  localparam logic [1:0] OP_MADD = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef struct packed {
    logic              v;
    logic [PREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
    logic              from_mul;
  } slot_t;

  slot_t              slot   [0:D];
  slot_t              slot_n [0:D];
  logic [MUL_LAT-1:0] fma_pend;
  logic [MUL_LAT-1:0] fma_pend_n;
  logic [LW-1:0]      lat;
  logic               issue;
  logic               issue_keep;

`ifdef FMA_SCHED_FLUSH_EN
  logic [ROB_W-1:0] pend_rob   [0:MUL_LAT-1];
  logic [ROB_W-1:0] pend_rob_n [0:MUL_LAT-1];

  // The MSB is a wrap flag: equal flags compare indices directly, differing flags invert the order.
  function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    if (a[ROB_W-1] == b[ROB_W-1]) return a[ROB_W-2:0] > b[ROB_W-2:0];
    return a[ROB_W-2:0] < b[ROB_W-2:0];
  endfunction

  assign issue_keep = issue && !(flush_en && younger(in_rob, flush_rob));
`else
  logic unused_flush;
  assign unused_flush = ^{flush_en, flush_rob};
  assign issue_keep   = issue;
`endif

  always_comb begin
    case (in_op)
      OP_ADD:  lat = LW'(ADD_LAT);
      OP_MUL:  lat = LW'(MUL_LAT);
      default: lat = LW'(D);
    endcase
    in_ready = (in_op != OP_RSVD) && !slot[lat].v && !(in_op == OP_ADD && fma_pend[0]);
  end

  assign issue     = in_valid && in_ready;
  assign mul_start = issue && (in_op == OP_MUL || in_op == OP_MADD);
  assign add_start = (issue && in_op == OP_ADD) || fma_pend[0];
  assign add_fma   = fma_pend[0];

  assign wb_valid     = slot[0].v;
  assign wb_rd        = slot[0].rd;
  assign wb_rob       = slot[0].rob;
  assign wb_from_mul  = slot[0].from_mul;
  assign wakeup_valid = slot[WAKE_AHEAD].v;
  assign wakeup_rd    = slot[WAKE_AHEAD].rd;

  // Ring shifts first; the new op lands in slot[L-1] on top of the shifted contents.
  always_comb begin
    for (int k = 0; k < D; k++) begin
      slot_n[k] = slot[k+1];
`ifdef FMA_SCHED_FLUSH_EN
      if (flush_en && younger(slot[k+1].rob, flush_rob)) slot_n[k].v = 1'b0;
`endif
    end
    slot_n[D] = '0;
    if (issue_keep)
      slot_n[lat - 1'b1] = '{v: 1'b1, rd: in_rd, rob: in_rob, from_mul: (in_op == OP_MUL)};
  end

  always_comb begin
    fma_pend_n = '0;
`ifdef FMA_SCHED_FLUSH_EN
    for (int k = 0; k < MUL_LAT; k++) pend_rob_n[k] = '0;
`endif
    for (int k = 0; k < MUL_LAT - 1; k++) begin
      fma_pend_n[k] = fma_pend[k+1];
`ifdef FMA_SCHED_FLUSH_EN
      pend_rob_n[k] = pend_rob[k+1];
      if (flush_en && younger(pend_rob[k+1], flush_rob)) fma_pend_n[k] = 1'b0;
`endif
    end
    if (issue_keep && in_op == OP_MADD) begin
      fma_pend_n[MUL_LAT-1] = 1'b1;
`ifdef FMA_SCHED_FLUSH_EN
      pend_rob_n[MUL_LAT-1] = in_rob;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k <= D; k++) slot[k] <= '0;
      fma_pend <= '0;
`ifdef FMA_SCHED_FLUSH_EN
      for (int k = 0; k < MUL_LAT; k++) pend_rob[k] <= '0;
`endif
    end else begin
      slot     <= slot_n;
      fma_pend <= fma_pend_n;
`ifdef FMA_SCHED_FLUSH_EN
      pend_rob <= pend_rob_n;
`endif
    end
  end
endmodule

// File: tb/tb_fma_sched.sv
// tb/tb_fma_sched.sv - self-checking bench for fma_sched: op-list reference model plus directed literals.
module tb_fma_sched;
  localparam int MUL_LAT    = 3;
  localparam int ADD_LAT    = 2;
  localparam int WAKE_AHEAD = 1;
  localparam int PREG_W     = 7;
  localparam int ROB_W      = 7;
  localparam int D          = MUL_LAT + ADD_LAT;
`ifdef FMA_SCHED_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        in_op = '0;
  logic [PREG_W-1:0] in_rd = '0;
  logic [ROB_W-1:0]  in_rob = '0;
  logic              flush_en = 1'b0;
  logic [ROB_W-1:0]  flush_rob = '0;
  logic              in_ready, mul_start, add_start, add_fma;
  logic              wakeup_valid, wb_valid, wb_from_mul;
  logic [PREG_W-1:0] wakeup_rd, wb_rd;
  logic [ROB_W-1:0]  wb_rob;

  always #5 clk = ~clk;

  fma_sched #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .WAKE_AHEAD(WAKE_AHEAD),
              .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd), .in_rob(in_rob),
    .in_ready(in_ready), .mul_start(mul_start), .add_start(add_start), .add_fma(add_fma),
    .wakeup_valid(wakeup_valid), .wakeup_rd(wakeup_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_rob(wb_rob), .wb_from_mul(wb_from_mul), .flush_en(flush_en), .flush_rob(flush_rob));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // One accepted op: the cycle it writes back and, for MADD, the cycle it enters the adder.
  typedef struct {
    int                wb;
    int                ac;
    logic [PREG_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
    bit                fm;
  } op_t;
  op_t ops[$];

  function automatic int lat_of(input logic [1:0] op);
    if (op == 2'd0) return ADD_LAT;
    if (op == 2'd1) return MUL_LAT;
    return MUL_LAT + ADD_LAT;
  endfunction

  function automatic bit younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    int fa, fb, ia, ib;
    fa = int'(a) >> (ROB_W - 1);
    fb = int'(b) >> (ROB_W - 1);
    ia = int'(a) % (1 << (ROB_W - 1));
    ib = int'(b) % (1 << (ROB_W - 1));
    return (fa == fb) ? (ia > ib) : (ia < ib);
  endfunction

  always @(negedge clk) begin : model_chk
    int  lat;
    bit  rdy, madd_now, exp_wb, exp_wk;
    op_t wbop, wkop;
    if (!rst) begin
      ops.delete();
    end else begin
      lat = lat_of(in_op);
      rdy = (in_op != 2'd3);
      madd_now = 1'b0;
      exp_wb = 1'b0;
      exp_wk = 1'b0;
      foreach (ops[i]) begin
        if (ops[i].wb == cyc + lat) rdy = 1'b0;
        if (ops[i].ac == cyc) madd_now = 1'b1;
        if (ops[i].wb == cyc) begin exp_wb = 1'b1; wbop = ops[i]; end
        if (ops[i].wb == cyc + WAKE_AHEAD) begin exp_wk = 1'b1; wkop = ops[i]; end
      end
      if (in_op == 2'd0 && madd_now) rdy = 1'b0;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("mul_start", 32'(mul_start), 32'(in_valid && rdy && (in_op == 2'd1 || in_op == 2'd2)));
      chk("add_start", 32'(add_start), 32'((in_valid && rdy && in_op == 2'd0) || madd_now));
      chk("add_fma", 32'(add_fma), 32'(madd_now));
      chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
      if (exp_wb) begin
        chk("wb_rd", 32'(wb_rd), 32'(wbop.rd));
        chk("wb_rob", 32'(wb_rob), 32'(wbop.rob));
        chk("wb_from_mul", 32'(wb_from_mul), 32'(wbop.fm));
      end
      chk("wakeup_valid", 32'(wakeup_valid), 32'(exp_wk));
      if (exp_wk) chk("wakeup_rd", 32'(wakeup_rd), 32'(wkop.rd));
      if (FLUSH && flush_en) begin
        foreach (ops[i]) begin
          if (younger(ops[i].rob, flush_rob) && ops[i].wb > cyc) begin
            ops[i].wb = -1;
            if (ops[i].ac > cyc) ops[i].ac = -1;
          end
        end
      end
      if (in_valid && rdy && !(FLUSH && flush_en && younger(in_rob, flush_rob)))
        ops.push_back('{wb: cyc + lat, ac: (in_op == 2'd2) ? cyc + MUL_LAT : -1,
                        rd: in_rd, rob: in_rob, fm: (in_op == 2'd1)});
      for (int i = ops.size() - 1; i >= 0; i--)
        if (ops[i].wb <= cyc && ops[i].ac <= cyc) ops.delete(i);
    end
    cyc++;
  end

  task automatic drive(input bit v, input logic [1:0] op, input int rd, input int rob,
                       input bit fl = 1'b0, input int frob = 0);
    in_valid  = v;
    in_op     = op;
    in_rd     = PREG_W'(rd);
    in_rob    = ROB_W'(rob);
    flush_en  = fl;
    flush_rob = ROB_W'(frob);
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench inside cycle 0 of a freshly reset DUT.
  task automatic reset_dut();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    reset_dut();
    drive(1'b1, 2'd3, 1, 1); #1;
    chk("rst_op3_never_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 2'd0, 0, 0); #1;
    chk("rst_add_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wakeup_valid", 32'(wakeup_valid), 32'd0);
    tick();
    drive(1'b0, 2'd1, 0, 0); #1;
    chk("rst_mul_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 2'd2, 0, 0); #1;
    chk("rst_madd_ready", 32'(in_ready), 32'd1);

    // MUL then colliding ADD
    reset_dut();
    drive(1'b1, 2'd1, 1, 1); #1;
    chk("t1_mul_start", 32'(mul_start), 32'd1);
    tick(); drive(1'b1, 2'd0, 2, 2); #1;
    chk("t1_add_blocked", 32'(in_ready), 32'd0);
    tick(); drive(1'b1, 2'd0, 2, 2); #1;
    chk("t1_add_accepted", 32'(in_ready), 32'd1);
    tick(); idle(); #1;
    chk("t1_wb3_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb3_rd", 32'(wb_rd), 32'd1);
    chk("t1_wb3_from_mul", 32'(wb_from_mul), 32'd1);
    tick(); #1;
    chk("t1_wb4_rd", 32'(wb_rd), 32'd2);
    chk("t1_wb4_from_mul", 32'(wb_from_mul), 32'd0);

    // MADD: adder entry at 3, wakeup at 4, writeback at 5
    reset_dut();
    drive(1'b1, 2'd2, 5, 5); #1;
    chk("t2_mul_start", 32'(mul_start), 32'd1);
    chk("t2_add_start0", 32'(add_start), 32'd0);
    tick(); idle();
    tick();
    tick(); drive(1'b1, 2'd0, 6, 6); #1;
    chk("t2_add_blocked", 32'(in_ready), 32'd0);
    chk("t2_add_start3", 32'(add_start), 32'd1);
    chk("t2_add_fma3", 32'(add_fma), 32'd1);
    tick(); idle(); #1;
    chk("t2_wakeup_valid", 32'(wakeup_valid), 32'd1);
    chk("t2_wakeup_rd", 32'(wakeup_rd), 32'd5);
    tick(); #1;
    chk("t2_wb_valid", 32'(wb_valid), 32'd1);
    chk("t2_wb_rd", 32'(wb_rd), 32'd5);

    // back-to-back ADDs
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      if (i < 10) drive(1'b1, 2'd0, 10 + i, i); else idle();
      #1;
      if (i < 10) chk("t3_ready", 32'(in_ready), 32'd1);
      if (i >= 2 && i < 12) begin
        chk("t3_wb_valid", 32'(wb_valid), 32'd1);
        chk("t3_wb_rd", 32'(wb_rd), 32'(10 + i - 2));
      end
      if (i == 12) chk("t3_wb_done", 32'(wb_valid), 32'd0);
      tick();
    end

    // redirect with same-cycle younger issue
    reset_dut();
    drive(1'b1, 2'd1, 9, 9);
    tick(); drive(1'b1, 2'd1, 11, 11, 1'b1, 10); #1;
    chk("t4_issue_ready", 32'(in_ready), 32'd1);
    tick(); drive(1'b1, 2'd0, 12, 12); #1;
`ifdef FMA_SCHED_FLUSH_EN
    chk("t4_slot_freed", 32'(in_ready), 32'd1);
`else
    chk("t4_slot_taken", 32'(in_ready), 32'd0);
`endif
    tick(); idle(); #1;
    chk("t4_wb3_rob", 32'(wb_rob), 32'd9);
    tick(); #1;
    chk("t4_wb4_valid", 32'(wb_valid), 32'd1);
`ifdef FMA_SCHED_FLUSH_EN
    chk("t4_wb4_rob", 32'(wb_rob), 32'd12);
`else
    chk("t4_wb4_rob", 32'(wb_rob), 32'd11);
`endif

    // wrap-flag comparison on in-flight ops
    reset_dut();
    drive(1'b1, 2'd1, 1, 'h43);
    tick(); drive(1'b1, 2'd1, 2, 3);
    tick(); drive(1'b0, 2'd0, 0, 0, 1'b1, 60);
    tick(); idle(); #1;
    chk("t5_wrapped_wb", 32'(wb_valid), 32'(!FLUSH));
    tick(); #1;
    chk("t5_older_wb", 32'(wb_valid), 32'd1);
    chk("t5_older_rob", 32'(wb_rob), 32'd3);

    // reset with a MADD in flight
    reset_dut();
    drive(1'b1, 2'd2, 5, 5);
    tick(); idle();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_wb_valid", 32'(wb_valid), 32'd0);
      chk("t6_wakeup_valid", 32'(wakeup_valid), 32'd0);
      chk("t6_add_start", 32'(add_start), 32'd0);
      chk("t6_add_fma", 32'(add_fma), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      tick();
    end

    // randomized traffic, redirects and occasional reset
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 127),
            $urandom_range(0, 127), $urandom_range(0, 11) == 0, $urandom_range(0, 127));
      rst = ($urandom_range(0, 149) != 0);
      tick();
    end
    idle();
    rst = 1'b1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
